// File: rtl/tc_ram_lat_ctrl_if.sv
// Client-side request/response stream for tc_ram_lat_ctrl.
// The master drives requests and consumes responses; the slave is the controller.
`timescale 1ns/1ps
interface tc_ram_lat_ctrl_if #(
   parameter int BIT_WIDTH = 16
);
   logic                 req_valid;
   logic                 req_ready;
   logic                 req_write;
   logic [15:0]          req_addr;
   logic [BIT_WIDTH-1:0] req_wdata0;
   logic [BIT_WIDTH-1:0] req_wdata1;
   logic [BIT_WIDTH-1:0] req_wdata2;
   logic [BIT_WIDTH-1:0] req_wdata3;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic                 rsp_write;
   logic                 rsp_err;
   logic [BIT_WIDTH-1:0] rsp_data0;
   logic [BIT_WIDTH-1:0] rsp_data1;
   logic [BIT_WIDTH-1:0] rsp_data2;
   logic [BIT_WIDTH-1:0] rsp_data3;

   modport master (
      output req_valid, req_write, req_addr,
             req_wdata0, req_wdata1, req_wdata2, req_wdata3, rsp_ready,
      input  req_ready, rsp_valid, rsp_write, rsp_err,
             rsp_data0, rsp_data1, rsp_data2, rsp_data3
   );

   modport slave (
      input  req_valid, req_write, req_addr,
             req_wdata0, req_wdata1, req_wdata2, req_wdata3, rsp_ready,
      output req_ready, rsp_valid, rsp_write, rsp_err,
             rsp_data0, rsp_data1, rsp_data2, rsp_data3
   );
endinterface

// File: rtl/tc_ram_lat_ctrl.sv
// Request controller in front of a 2-cycle-latency 4-word RAM; returns every request as a held response.
// Optional RD_WAIT watchdog enabled by defining TC_RAM_LAT_CTRL_TIMEOUT_EN.
`timescale 1ns/1ps
module tc_ram_lat_ctrl #(
   parameter int BIT_WIDTH      = 16,
   parameter int MEM_WORDS      = 256,
   parameter int TIMEOUT_CYCLES = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   tc_ram_lat_ctrl_if.slave     bus,
   output logic                 ram_load,
   output logic                 ram_save,
   output logic [15:0]          ram_address,
   output logic [BIT_WIDTH-1:0] ram_in0,
   output logic [BIT_WIDTH-1:0] ram_in1,
   output logic [BIT_WIDTH-1:0] ram_in2,
   output logic [BIT_WIDTH-1:0] ram_in3,
   input  logic                 ram_ready,
   input  logic [BIT_WIDTH-1:0] ram_out0,
   input  logic [BIT_WIDTH-1:0] ram_out1,
   input  logic [BIT_WIDTH-1:0] ram_out2,
   input  logic [BIT_WIDTH-1:0] ram_out3
);
   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] RD_ISSUE = 3'd1;
   localparam logic [2:0] RD_WAIT  = 3'd2;
   localparam logic [2:0] WR_ISSUE = 3'd3;
   localparam logic [2:0] RESP     = 3'd4;

   // Highest legal base address: base+3 must still be inside the RAM.
   localparam logic [15:0] MAX_BASE = 16'(MEM_WORDS - 4);

   logic [2:0] state;
   logic       accept;
   logic       range_err;
   logic       timed_out;

   assign accept    = bus.req_valid && bus.req_ready;
   assign range_err = bus.req_addr > MAX_BASE;

`ifdef TC_RAM_LAT_CTRL_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] wait_cnt;

   assign timed_out = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

   // Counts cycles spent in RD_WAIT; held at 0 everywhere else so it starts fresh on entry.
   always_ff @(posedge clk) begin
      if (rst || state != RD_WAIT) begin
         wait_cnt <= '0;
      end else if (!timed_out) begin
         wait_cnt <= wait_cnt + CW'(1);
      end
   end
`else
   // Watchdog compiled out: RD_WAIT can only be left through ram_ready.
   assign timed_out = (TIMEOUT_CYCLES < 0);
`endif

   // RAM strobes default low every cycle, so address/data read as 0 whenever no strobe is up.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         bus.req_ready <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_write <= 1'b0;
         bus.rsp_err   <= 1'b0;
         bus.rsp_data0 <= '0;
         bus.rsp_data1 <= '0;
         bus.rsp_data2 <= '0;
         bus.rsp_data3 <= '0;
         ram_load      <= 1'b0;
         ram_save      <= 1'b0;
         ram_address   <= '0;
         ram_in0       <= '0;
         ram_in1       <= '0;
         ram_in2       <= '0;
         ram_in3       <= '0;
      end else begin
         ram_load    <= 1'b0;
         ram_save    <= 1'b0;
         ram_address <= '0;
         ram_in0     <= '0;
         ram_in1     <= '0;
         ram_in2     <= '0;
         ram_in3     <= '0;
         case (state)
            IDLE: begin
               bus.req_ready <= 1'b1;
               if (accept) begin
                  bus.req_ready <= 1'b0;
                  if (range_err) begin
                     state         <= RESP;
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_err   <= 1'b1;
                     bus.rsp_write <= bus.req_write;
                  end else if (bus.req_write) begin
                     state       <= WR_ISSUE;
                     ram_save    <= 1'b1;
                     ram_address <= bus.req_addr;
                     ram_in0     <= bus.req_wdata0;
                     ram_in1     <= bus.req_wdata1;
                     ram_in2     <= bus.req_wdata2;
                     ram_in3     <= bus.req_wdata3;
                  end else begin
                     state       <= RD_ISSUE;
                     ram_load    <= 1'b1;
                     ram_address <= bus.req_addr;
                  end
               end
            end
            RD_ISSUE: begin
               state <= RD_WAIT;
            end
            RD_WAIT: begin
               if (ram_ready) begin
                  state         <= RESP;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_data0 <= ram_out0;
                  bus.rsp_data1 <= ram_out1;
                  bus.rsp_data2 <= ram_out2;
                  bus.rsp_data3 <= ram_out3;
               end else if (timed_out) begin
                  state         <= RESP;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= 1'b1;
               end
            end
            WR_ISSUE: begin
               state         <= RESP;
               bus.rsp_valid <= 1'b1;
               bus.rsp_write <= 1'b1;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  state         <= IDLE;
                  bus.req_ready <= 1'b1;
                  bus.rsp_valid <= 1'b0;
                  bus.rsp_write <= 1'b0;
                  bus.rsp_err   <= 1'b0;
                  bus.rsp_data0 <= '0;
                  bus.rsp_data1 <= '0;
                  bus.rsp_data2 <= '0;
                  bus.rsp_data3 <= '0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
